// File: rtl/clz_pkg.sv
// rtl/clz_pkg.sv - shared constants, width helper and stage payload type for clz_pipe
package clz_pkg;

  localparam logic MODE_CLZ = 1'b0;
  localparam logic MODE_CLO = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 5;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

  // Count must reach WIDTH itself, hence one bit more than log2.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic [DEF_WIDTH-1:0] window;
    logic [DEF_CNT_W-1:0] count;
    logic                 zero;
    logic [DEF_TAG_W-1:0] tag;
  } stagePayloadT;

endpackage

// File: rtl/clz_pipe_if.sv
// rtl/clz_pipe_if.sv - operand/result handshake bundle for clz_pipe
interface clz_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import clz_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_tag
  );

endinterface

// File: rtl/clz_stage.sv
// rtl/clz_stage.sv - one binary-search halving level of the leading-zero count
module clz_stage #(
  parameter int WIN_W = 32,
  parameter int CNT_W = 6
) (
  input  logic [WIN_W-1:0]   winIn,
  input  logic [CNT_W-1:0]   cntIn,
  output logic [WIN_W/2-1:0] winOut,
  output logic [CNT_W-1:0]   cntOut
);
  localparam int HALF = WIN_W / 2;

  logic upperZero;

  assign upperZero = (winIn[WIN_W-1:HALF] == '0);
  assign winOut    = upperZero ? winIn[HALF-1:0] : winIn[WIN_W-1:HALF];
  assign cntOut    = upperZero ? cntIn + CNT_W'(HALF) : cntIn;

endmodule

// File: rtl/clz_pipe.sv
// rtl/clz_pipe.sv - pipelined CLZ/CLO unit with tag pass-through and flush
module clz_pipe
  import clz_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic       clock,
  input logic       reset,
  input logic       flush,
  clz_pipe_if.slave io
);
  localparam int L     = $clog2(WIDTH);
  localparam int CNT_W = cnt_w(WIDTH);

  logic                    adv;
  logic [WIDTH-1:0]        w0;
  logic [L-1:0]            stgVld;
  // Windows shrink per stage; stage k sits at offset 2*WIDTH-2*(WIDTH>>k).
  logic [2*WIDTH-3:0]      winQ;
  logic [L-1:0][CNT_W-1:0] cntQ;
  logic [L-1:0][CNT_W-1:0] cntNext;
  logic [L-1:0]            zeroQ;
  logic [L-1:0][TAG_W-1:0] tagQ;
  logic [WIDTH-2:0]        winNext;
  logic [CNT_W-1:0]        finalCnt;

  assign adv         = ~io.out_valid | io.out_ready;
  assign io.in_ready = adv & ~flush;
  assign w0          = (io.in_mode == MODE_CLO) ? ~io.in_data : io.in_data;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int WW   = WIDTH >> k;
    localparam int WOFF = 2 * WIDTH - 2 * WW;
    localparam int NOFF = WIDTH - WW;

    clz_stage #(
      .WIN_W(WW),
      .CNT_W(CNT_W)
    ) u_stage (
      .winIn (winQ[WOFF+WW-1:WOFF]),
      .cntIn (cntQ[k]),
      .winOut(winNext[NOFF+WW/2-1:NOFF]),
      .cntOut(cntNext[k])
    );
  end

  // The surviving single bit still counts as a leading zero when clear.
  assign finalCnt = cntNext[L-1] + {{(CNT_W-1){1'b0}}, ~winNext[WIDTH-2]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stgVld       <= '0;
      winQ         <= '0;
      cntQ         <= '0;
      zeroQ        <= '0;
      tagQ         <= '0;
      io.out_valid <= 1'b0;
      io.out_count <= '0;
      io.out_zero  <= 1'b0;
      io.out_tag   <= '0;
    end else begin
      if (flush) begin
        stgVld       <= '0;
        io.out_valid <= 1'b0;
      end else if (adv) begin
        stgVld       <= {stgVld[L-2:0], io.in_valid};
        io.out_valid <= stgVld[L-1];
      end
      if (adv) begin
        winQ         <= {winNext[WIDTH-3:0], w0};
        cntQ         <= {cntNext[L-2:0], {CNT_W{1'b0}}};
        zeroQ        <= {zeroQ[L-2:0], (w0 == '0)};
        tagQ         <= {tagQ[L-2:0], io.in_tag};
        io.out_count <= finalCnt;
        io.out_zero  <= zeroQ[L-1];
        io.out_tag   <= tagQ[L-1];
      end
    end
  end

endmodule

// File: doc/clz_pipe.md
# clz_pipe

Parametrised, pipelined count-leading-zeros / count-leading-ones unit for the MIPS datapath's multi-cycle functional-unit slot. It generalises the 32-bit combinational `clz` to any power-of-two `WIDTH`, adds a CLO mode, and adds an all-zero flag. Results are registered through a log2(`WIDTH`)-stage binary-search pipeline. The block exchanges operands and results over valid/ready handshakes and carries a destination tag alongside each operand.

## Interface
- `WIDTH`, 32: operand width; power of two, ≥4.
- `TAG_W`, 5: width of the tag carried with each operand (default suits the register number).
- `clock` in 1: rising-edge clock; the block's only clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `flush` in 1: synchronous; discards all in-flight operations.
- `in_valid` in 1: operand present.
- `in_ready` out 1: operand accepted when `in_valid & in_ready`.
- `in_data` in `WIDTH`: operand.
- `in_mode` in 1: 0 = CLZ, 1 = CLO.
- `in_tag` in `TAG_W`: passed through unchanged.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid & out_ready`.
- `out_count` out `CNT_W` = log2(`WIDTH`)+1: leading-zero count (CLZ) or leading-one count (CLO), range 0..`WIDTH`.
- `out_zero` out 1: the normalised operand was all zeros, so `out_count` = `WIDTH`.
- `out_tag` out `TAG_W`: tag of the result.

## Operation
- L = log2(`WIDTH`) stages. Each stage holds a valid bit, a window, a partial count, a tag and a zero flag.
- Normalise at input: `w0` = `in_mode` ? ~`in_data` : `in_data`. Count is 0 and zero flag is (`w0`==0).
- Stage k (k = 0..L-1) takes a window of width `WIDTH`>>k, with h = half that width:
  - If the upper h bits are 0: count += h and the next window is the lower half.
  - Otherwise the next window is the upper half.
- The last stage also adds ~(final 1-bit window) to the count.
- Counts are unsigned `CNT_W` bits and cannot overflow; the maximum is `WIDTH`.
- Advance rule: `adv` = ~`out_valid` | `out_ready`. When `adv` is high, every stage loads from its predecessor and stage 0 loads the input. When `adv` is low, every stage holds.
- `in_ready` = `adv` & ~`flush`.
- Bubbles are not collapsed. An invalid slot moves through the pipeline like data.
- `flush`:
  - Clears every valid bit at the next edge.
  - Has priority over `in_valid` and over `adv`.
  - No operation accepted during the flush cycle is kept.
- Mode is latched per operand. Mixed CLZ/CLO back-to-back traffic is legal.

## Timing
- Latency: an operand accepted at edge n presents `out_valid` = 1 with its result after edge n+L (5 cycles for `WIDTH`=32).
- Throughput: 1 operand per cycle while `out_ready` is held high.
- Stall: if `out_valid` & ~`out_ready`, all outputs and all stages hold and `in_ready` = 0 in that same cycle (combinational from `out_ready`).
- Outputs are register-driven, except `in_ready`.
- Reset values: `out_valid` 0, `out_count` 0, `out_zero` 0, `out_tag` 0, all stage valid bits 0, all stage data 0. Consequently `in_ready` = 1 after reset.
- Reset asserted mid-operation: all in-flight results are lost immediately and asynchronously. No result appears after deassertion.
- `flush` together with `out_valid` & `out_ready`: the output is consumed and `out_valid` goes 0 at the next edge.

## Structure
- Package `clz_pkg`:
  - `MODE_CLZ` = 1'b0 and `MODE_CLO` = 1'b1.
  - `cnt_w(WIDTH)` function.
  - Stage payload struct/typedef (window, count, zero, tag).
- Sub-module `clz_stage`, parametrised by window width: one halving level, purely combinational.
- `clz_pipe` instantiates L `clz_stage` instances in a generate loop and owns all registers and the `adv`/`flush` control.

## Test plan
Directed tests use `WIDTH`=32 and `TAG_W`=5.
- Latency and CLZ: CLZ `0x00010000`, tag 7, `out_ready`=1 → after 5 edges, `out_count`=15, `out_tag`=7, `out_zero`=0, `out_valid` high for one cycle.
- CLO mode: CLO `0xFFFF0000` → 16. CLO `0x7FFFFFFF` → 0. CLO `0xFFFFFFFF` → 32 with `out_zero`=1.
- CLZ extremes: `0x00000000` → 32, `out_zero`=1. `0x80000000` → 0. `0x00000001` → 31.
- Back-to-back and stall:
  - Stream 8 operands with tags 0..7 every cycle, results in order.
  - Drop `out_ready` for 3 cycles at result 2. `out_count`/`out_tag` hold, `in_ready`=0, and no result is lost or duplicated.
- Flush: accept 3 operands, assert `flush` one cycle later → no `out_valid` ever. An operand offered during flush is not accepted. The next operand after flush returns normally 5 edges later.
- Reset mid-operation: assert `reset` with 4 operands in flight → `out_valid` drops at once. After release, `in_ready`=1 and nothing emerges.
